// File: rtl/branch_unit_if.sv
// Branch request / redirect bundle between decode/ALU/fetch and branch_unit.
// master drives requests and flags; slave (branch_unit) returns the redirect.
interface branch_unit_if #(
    parameter int ADDR_W = 16
);
    logic              req_i;
    logic [1:0]        kind_i;
    logic [3:0]        cond_i;
    logic [ADDR_W-1:0] pc_i;
    logic [ADDR_W-1:0] target_i;
    logic              flag_we_i;
    logic [3:0]        flag_i;
    logic              flush_i;
    logic              redirect_o;
    logic [ADDR_W-1:0] target_o;
    logic [3:0]        flags_o;
    logic              ras_err_o;

    modport master (
        output req_i, kind_i, cond_i, pc_i, target_i, flag_we_i, flag_i, flush_i,
        input  redirect_o, target_o, flags_o, ras_err_o
    );

    modport slave (
        input  req_i, kind_i, cond_i, pc_i, target_i, flag_we_i, flag_i, flush_i,
        output redirect_o, target_o, flags_o, ras_err_o
    );
endinterface

// File: rtl/branch_unit.sv
// Branch resolution: flag register with same-cycle bypass, 16 conditions, registered redirect.
// Optional return-address stack enabled by defining BRANCH_RAS_EN.
module branch_unit #(
    parameter int ADDR_W    = 16,
    parameter int RAS_DEPTH = 4
) (
    input logic         clk_i,
    input logic         rst_i,
    branch_unit_if.slave bus
);
    localparam logic [1:0] KIND_JMP  = 2'b00;
    localparam logic [1:0] KIND_CALL = 2'b01;
    localparam logic [1:0] KIND_RET  = 2'b10;
    localparam logic [1:0] KIND_RSV  = 2'b11;

    logic [3:0]        flags_q, flags_d, flags_eff;
    logic              redirect_q, redirect_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              err_q, err_d;
    logic              f_z, f_c, f_n, f_v;
    logic              cond_true, accepted, taken;

`ifdef BRANCH_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 2) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_dec;
    logic [PTR_W:0]    cnt_q, cnt_d;
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_pc;
    assign unused_pc = ^bus.pc_i;
`endif

    always_comb begin
        flags_eff = bus.flag_we_i ? bus.flag_i : flags_q;
        f_z = flags_eff[0];
        f_c = flags_eff[1];
        f_n = flags_eff[2];
        f_v = flags_eff[3];

        cond_true = 1'b0;
        unique case (bus.cond_i)
            4'd0:  cond_true = 1'b1;
            4'd1:  cond_true = f_z;
            4'd2:  cond_true = !f_z;
            4'd3:  cond_true = f_c;
            4'd4:  cond_true = !f_c;
            4'd5:  cond_true = f_n;
            4'd6:  cond_true = !f_n;
            4'd7:  cond_true = f_v;
            4'd8:  cond_true = !f_v;
            4'd9:  cond_true = f_c && !f_z;
            4'd10: cond_true = !f_c || f_z;
            4'd11: cond_true = (f_n == f_v);
            4'd12: cond_true = (f_n != f_v);
            4'd13: cond_true = !f_z && (f_n == f_v);
            4'd14: cond_true = f_z || (f_n != f_v);
            4'd15: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase

        accepted = bus.req_i && !bus.flush_i && (bus.kind_i != KIND_RSV);
        taken    = accepted && cond_true;

        flags_d    = flags_eff;
        redirect_d = taken;
        target_d   = taken ? bus.target_i : target_q;
        err_d      = err_q;

`ifdef BRANCH_RAS_EN
        ras_d   = ras_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ptr_dec = ptr_q - 1'b1;
        // ptr_q is the next free slot; a full-stack push wraps over the oldest entry
        if (taken && bus.kind_i == KIND_CALL) begin
            ras_d[ptr_q] = bus.pc_i + 1'b1;
            ptr_d        = ptr_q + 1'b1;
            if (cnt_q == CNT_FULL) err_d = 1'b1;
            else                   cnt_d = cnt_q + 1'b1;
        end else if (taken && bus.kind_i == KIND_RET) begin
            if (cnt_q == '0) begin
                target_d = '0;
                err_d    = 1'b1;
            end else begin
                target_d = ras_q[ptr_dec];
                ptr_d    = ptr_dec;
                cnt_d    = cnt_q - 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flags_q    <= '0;
            redirect_q <= 1'b0;
            target_q   <= '0;
            err_q      <= 1'b0;
`ifdef BRANCH_RAS_EN
            ptr_q      <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
`endif
        end else begin
            flags_q    <= flags_d;
            redirect_q <= redirect_d;
            target_q   <= target_d;
            err_q      <= err_d;
`ifdef BRANCH_RAS_EN
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            ras_q      <= ras_d;
`endif
        end
    end

    assign bus.redirect_o = redirect_q;
    assign bus.target_o   = target_q;
    assign bus.flags_o    = flags_q;
`ifdef BRANCH_RAS_EN
    assign bus.ras_err_o  = err_q;
`else
    assign bus.ras_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: driver pushes reference-model expectations,
// monitor pops and compares one entry per clock after each rising edge.
module tb_branch_unit;
    localparam int AW    = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_unit_if #(.ADDR_W(AW)) bus ();

    branch_unit #(.ADDR_W(AW), .RAS_DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic          red;
        logic [AW-1:0] tgt;
        logic [3:0]    flags;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    // reference state
    logic [3:0]    m_flags = '0;
    logic [AW-1:0] m_tgt   = '0;
    logic          m_err   = 1'b0;
    logic [AW-1:0] m_ras[$];

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic z, cy, n, v;
        z = f[0]; cy = f[1]; n = f[2]; v = f[3];
        case (c)
            4'd0:  return 1'b1;
            4'd1:  return z;
            4'd2:  return !z;
            4'd3:  return cy;
            4'd4:  return !cy;
            4'd5:  return n;
            4'd6:  return !n;
            4'd7:  return v;
            4'd8:  return !v;
            4'd9:  return cy && !z;
            4'd10: return !cy || z;
            4'd11: return n == v;
            4'd12: return n != v;
            4'd13: return !z && (n == v);
            4'd14: return z || (n != v);
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic r, input logic req, input logic [1:0] kind,
                         input logic [3:0] cond, input logic [AW-1:0] pc,
                         input logic [AW-1:0] tgt, input logic fwe,
                         input logic [3:0] fl, input logic flush);
        exp_t          e;
        logic          taken;
        logic [3:0]    eff;
        logic [AW-1:0] link;
        @(negedge clk);
        rst           = r;
        bus.req_i     = req;
        bus.kind_i    = kind;
        bus.cond_i    = cond;
        bus.pc_i      = pc;
        bus.target_i  = tgt;
        bus.flag_we_i = fwe;
        bus.flag_i    = fl;
        bus.flush_i   = flush;
        if (r) begin
            m_flags = '0; m_tgt = '0; m_err = 1'b0; m_ras.delete();
            taken   = 1'b0;
        end else begin
            eff   = fwe ? fl : m_flags;
            taken = req && !flush && (kind != 2'b11) && cond_holds(cond, eff);
            link  = pc + 16'd1;
            if (taken) begin
                case (kind)
                    2'b00: m_tgt = tgt;
                    2'b01: begin
                        m_tgt = tgt;
`ifdef BRANCH_RAS_EN
                        if (m_ras.size() == DEPTH) begin
                            void'(m_ras.pop_front());
                            m_err = 1'b1;
                        end
                        m_ras.push_back(link);
`endif
                    end
                    2'b10: begin
`ifdef BRANCH_RAS_EN
                        if (m_ras.size() == 0) begin
                            m_tgt = '0;
                            m_err = 1'b1;
                        end else begin
                            m_tgt = m_ras.pop_back();
                        end
`else
                        m_tgt = tgt;
`endif
                    end
                    default: ;
                endcase
            end
            if (fwe) m_flags = fl;
        end
        e.red = taken; e.tgt = m_tgt; e.flags = m_flags; e.err = m_err;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req_v);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("redirect", AW'(bus.redirect_o), AW'(e.red));
                check("target",   bus.target_o,        e.tgt);
                check("flags",    AW'(bus.flags_o),    AW'(e.flags));
                check("ras_err",  AW'(bus.ras_err_o),  AW'(e.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_i = 0; bus.kind_i = 0; bus.cond_i = 0; bus.pc_i = 0; bus.target_i = 0;
        bus.flag_we_i = 0; bus.flag_i = 0; bus.flush_i = 0;

        // reset with a live request, then bypass JMP on Z
        drive(1, 1, 2'b00, 4'd0, 16'h0000, 16'h1234, 0, 4'h0, 0);
        drive(1, 1, 2'b00, 4'd0, 16'h0000, 16'h1234, 1, 4'hF, 0);
        drive(0, 1, 2'b00, 4'd1, 16'h0002, 16'h0040, 1, 4'b0001, 0);
        drive(0, 0, 2'b00, 4'd0, 16'h0000, 16'h0000, 0, 4'h0, 0);

        // signed compares with N=1, V=0; reserved kind; never
        drive(0, 0, 2'b00, 4'd0, 16'h0000, 16'h0000, 1, 4'b0100, 0);
        drive(0, 1, 2'b00, 4'd12, 16'h0003, 16'h0200, 0, 4'h0, 0);
        drive(0, 1, 2'b00, 4'd11, 16'h0004, 16'h0300, 0, 4'h0, 0);
        drive(0, 1, 2'b00, 4'd15, 16'h0005, 16'h0400, 0, 4'h0, 0);
        drive(0, 1, 2'b11, 4'd0,  16'h0006, 16'h0500, 0, 4'h0, 0);
        for (int c = 0; c < 16; c++)
            drive(0, 1, 2'b00, 4'(c), 16'h0007, 16'(16'h1000 + c), 0, 4'h0, 0);

        // call / return / return-on-empty
        drive(1, 0, 2'b00, 4'd0, 16'h0000, 16'h0000, 0, 4'h0, 0);
        drive(0, 1, 2'b01, 4'd0, 16'h0010, 16'h0100, 0, 4'h0, 0);
        drive(0, 1, 2'b10, 4'd0, 16'h0100, 16'h0777, 0, 4'h0, 0);
        drive(0, 1, 2'b10, 4'd0, 16'h0101, 16'h0778, 0, 4'h0, 0);
        drive(0, 0, 2'b00, 4'd0, 16'h0000, 16'h0000, 0, 4'h0, 0);

        // overflow: 5 calls then 4 returns
        drive(1, 0, 2'b00, 4'd0, 16'h0000, 16'h0000, 0, 4'h0, 0);
        for (int i = 1; i <= 5; i++)
            drive(0, 1, 2'b01, 4'd0, 16'(i), 16'h0800, 0, 4'h0, 0);
        for (int i = 0; i < 4; i++)
            drive(0, 1, 2'b10, 4'd0, 16'h0900, 16'h0A00, 0, 4'h0, 0);

        // flush kills request; flush after accepted request does not kill redirect
        drive(1, 0, 2'b00, 4'd0, 16'h0000, 16'h0000, 0, 4'h0, 0);
        drive(0, 1, 2'b01, 4'd0, 16'h0020, 16'h0123, 0, 4'h0, 1);
        drive(0, 1, 2'b01, 4'd0, 16'h0030, 16'h0456, 0, 4'h0, 0);
        drive(0, 1, 2'b10, 4'd0, 16'h0040, 16'h0ABC, 0, 4'h0, 1);
        drive(0, 1, 2'b10, 4'd0, 16'h0050, 16'h0ABC, 0, 4'h0, 0);
        drive(0, 0, 2'b00, 4'd0, 16'h0000, 16'h0000, 0, 4'h0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] c;
            c = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)),
                  c,
                  16'($urandom),
                  16'($urandom),
                  $urandom_range(0, 3) == 0,
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 7) == 0);
        end
        drive(0, 0, 2'b00, 4'd0, 16'h0000, 16'h0000, 0, 4'h0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised branch resolution unit for the next-generation CPU core. It holds the architectural condition flags (Z, C, N, V) and evaluates one of 16 branch conditions per request, with same-cycle flag bypass. It resolves jump, call and return targets, including an optional hardware return-address stack. The decision and target are registered and presented to fetch one cycle after the request, as a single-cycle redirect pulse.

## Interface
Parameters:
- ADDR_W, 16, width of PC and target addresses
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  branch request valid (replaces ctrl_jmp_i)
- kind_i  in  2  00 JMP, 01 CALL, 10 RET, 11 reserved (treated as no-op)
- cond_i  in  4  condition code (see Operation)
- pc_i  in  ADDR_W  address of the branch instruction
- target_i  in  ADDR_W  decoded target for JMP/CALL
- flag_we_i  in  1  flag write enable from ALU
- flag_i  in  4  new flags {V,N,C,Z}
- flush_i  in  1  pipeline flush; kills request in same cycle
- redirect_o  out  1  one-cycle pulse: take branch
- target_o  out  ADDR_W  redirect address, valid when redirect_o=1
- flags_o  out  4  current architectural flags {V,N,C,Z}
- ras_err_o  out  1  sticky: RET on empty stack or CALL on full stack

## Operation
- Flags register: on flag_we_i, flags ← flag_i. Condition evaluation uses flag_i when flag_we_i=1 in the same cycle, else stored flags.
- cond_i: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 !N, 7 V, 8 !V, 9 C&!Z (unsigned >), 10 !C|Z (unsigned ≤), 11 N==V (signed ≥), 12 N!=V (signed <), 13 !Z&(N==V) (signed >), 14 Z|(N!=V) (signed ≤), 15 never.
- A request is accepted when req_i=1, flush_i=0, kind_i≠11. taken = accepted & cond_true.
- JMP taken: target = target_i.
- CALL taken: target = target_i; push pc_i+1 (mod 2^ADDR_W) to RAS.
- RET taken: target = popped RAS entry.
- Not-taken requests do not touch the RAS.
- Registered outputs: redirect_o ← taken, target_o ← target (target_o holds its last value when redirect_o=0).
- flush_i=1 in the cycle after an accepted request does not suppress the already-registered redirect_o.

## Timing
- Latency: request at edge N → redirect_o/target_o valid for cycle N+1, exactly one cycle. No backpressure; one request per cycle sustained.
- Back-to-back CALL then RET: the RET in the next cycle pops the address just pushed (the stack pointer updates at the edge).
- Reset values: redirect_o=0, target_o=0, flags_o=0, ras_err_o=0, RAS pointer=0 (empty), RAS entries=0.
- Reset has priority over all inputs, including a simultaneous req_i.
- flags_o reflects the registered flags (no bypass).

## Configuration
- BRANCH_RAS_EN defined: the RAS is RAS_DEPTH entries with a count of 0..RAS_DEPTH.
  - CALL on full stack: overwrites the oldest entry (circular), count stays RAS_DEPTH, ras_err_o set.
  - RET on empty stack: target_o=0, redirect_o=1, ras_err_o set.
  - ras_err_o is cleared only by rst_i.
- BRANCH_RAS_EN undefined: no stack.
  - CALL behaves as JMP.
  - RET redirects to target_i (software link register).
  - ras_err_o is tied to 0.
  - RAS_DEPTH is ignored.

## Test plan
- Reset: assert rst_i with req_i=1, cond=0 → redirect_o=0, target_o=0, flags_o=0 for the next cycle.
- Bypass: flag_we_i=1, flag_i=0001, with JMP cond=1 (Z) and target 0x0040 in the same cycle → next cycle redirect_o=1, target_o=0x0040; flags_o=0001.
- Signed compare: flags {V,N,C,Z}=0100, cond=12 → taken; cond=11 → redirect_o=0; cond=15 → never taken; kind_i=11 → no redirect.
- Call/return (RAS on): CALL at pc 0x0010 → 0x0100, then RET next cycle → redirect to 0x0011; a second RET → target_o=0, ras_err_o=1.
- Overflow (RAS on, depth 4): 5 CALLs at pcs 0x1..0x5, then 4 RETs → targets 0x6, 0x5, 0x4, 0x3; ras_err_o=1 after the fifth CALL.
- Flush: req_i with flush_i=1, cond=0 → redirect_o=0, RAS unchanged; with RAS off, RET with target_i=0x0ABC → target_o=0x0ABC.
